// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled N-bit Johnson counter value into a phase index/strobe, checks
// transitions and counts revolutions. Optional error counter: `define JPD_ERR_COUNT_EN.
module johnson_phase_decoder #(
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       en_i,
  input  logic [N-1:0]               q_i,
  input  logic                       err_clr_i,
  output logic [$clog2(2*N)-1:0]     phase_idx_o,
  output logic [2*N-1:0]             phase_onehot_o,
  output logic                       phase_valid_o,
  output logic                       rev_tick_o,
  output logic [CW-1:0]              rev_count_o,
`ifdef JPD_ERR_COUNT_EN
  output logic [7:0]                 err_count_o,
`endif
  output logic                       seq_err_o
);

  localparam int IW = $clog2(2*N);
  localparam int P  = 2*N;
  localparam logic [N-1:0] ONES = {N{1'b1}};
  localparam logic [IW-1:0] LAST_IDX = IW'(P-1);

  // Phases 0..N fill ones from the MSB; phases N+1..2N-1 drain them toward the LSB.
  function automatic logic [N-1:0] jcode(input int k);
    if (k <= N) return ~(ONES >> k);
    else        return ONES >> (k - N);
  endfunction

  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          have_ref_q, have_ref_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] rev_q, rev_d;
  logic          err_q, err_d;

  logic          dec_valid;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] next_idx;
  logic          err_event;

  always_comb begin
    dec_valid = 1'b0;
    dec_idx   = '0;
    for (int k = 0; k < P; k++) begin
      if (q_i == jcode(k)) begin
        dec_valid = 1'b1;
        dec_idx   = IW'(k);
      end
    end
  end

  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_comb begin
    idx_d      = idx_q;
    valid_d    = valid_q;
    have_ref_d = have_ref_q;
    tick_d     = 1'b0;
    rev_d      = rev_q;
    err_event  = 1'b0;
    if (en_i) begin
      if (!dec_valid) begin
        // phase_idx holds; losing the reference makes the next legal code a resync
        valid_d    = 1'b0;
        have_ref_d = 1'b0;
        err_event  = 1'b1;
      end else begin
        if (have_ref_q) begin
          if (dec_idx == next_idx) begin
            if (idx_q == LAST_IDX) begin
              tick_d = 1'b1;
              rev_d  = rev_q + 1'b1;
            end
          end else if (dec_idx != idx_q) begin
            err_event = 1'b1;
          end
        end
        idx_d      = dec_idx;
        valid_d    = 1'b1;
        have_ref_d = 1'b1;
      end
    end
    if (err_event)      err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q      <= '0;
      valid_q    <= 1'b0;
      have_ref_q <= 1'b0;
      tick_q     <= 1'b0;
      rev_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      have_ref_q <= have_ref_d;
      tick_q     <= tick_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
    end
  end

`ifdef JPD_ERR_COUNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (err_clr_i)                       ecnt_d = err_event ? 8'd1 : 8'd0;
    else if (err_event && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ecnt_q <= '0;
    else          ecnt_q <= ecnt_d;
  end

  assign err_count_o = ecnt_q;
`endif

  assign phase_idx_o    = idx_q;
  assign phase_valid_o  = valid_q;
  assign phase_onehot_o = valid_q ? (P'(1) << idx_q) : '0;
  assign rev_tick_o     = tick_q;
  assign rev_count_o    = rev_q;
  assign seq_err_o      = err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Randomized bench for johnson_phase_decoder against a phase-table reference model.
// Builds with or without JPD_ERR_COUNT_EN.
module tb_johnson_phase_decoder;
  localparam int N  = 3;
  localparam int P  = 2*N;
  localparam int CW = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_n_i, en_i, err_clr_i;
  logic [N-1:0] q_i;
  logic [2:0]   phase_idx_o;
  logic [P-1:0] phase_onehot_o;
  logic         phase_valid_o, rev_tick_o, seq_err_o;
  logic [CW-1:0] rev_count_o;
`ifdef JPD_ERR_COUNT_EN
  logic [7:0]   err_count_o;
`endif

  johnson_phase_decoder #(.N(N), .CW(CW)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .en_i          (en_i),
    .q_i           (q_i),
    .err_clr_i     (err_clr_i),
    .phase_idx_o   (phase_idx_o),
    .phase_onehot_o(phase_onehot_o),
    .phase_valid_o (phase_valid_o),
    .rev_tick_o    (rev_tick_o),
    .rev_count_o   (rev_count_o),
`ifdef JPD_ERR_COUNT_EN
    .err_count_o   (err_count_o),
`endif
    .seq_err_o     (seq_err_o)
  );

  int checks   = 0;
  int failures = 0;

  // Legal codes in counting order, generated by running the counter itself.
  logic [N-1:0] jtab [P];

  int m_idx, m_rev, m_ecnt;
  bit m_valid, m_have, m_err, m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [N-1:0] v);
    for (int k = 0; k < P; k++) if (jtab[k] == v) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_rev = 0; m_ecnt = 0;
    m_valid = 0; m_have = 0; m_err = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit en, input logic [N-1:0] q, input bit clr);
    int k, d;
    bit ev;
    ev = 0;
    m_tick = 0;
    if (en) begin
      k = lookup(q);
      if (k < 0) begin
        m_valid = 0; m_have = 0; ev = 1;
      end else begin
        if (m_have) begin
          d = (k - m_idx + P) % P;
          if (d == 1 && k == 0) m_tick = 1;
          else if (d > 1) ev = 1;
        end
        m_idx = k; m_valid = 1; m_have = 1;
      end
    end
    if (m_tick) m_rev = (m_rev + 1) % (1 << CW);
    if (ev) m_err = 1;
    else if (clr) m_err = 0;
    if (clr) m_ecnt = ev ? 1 : 0;
    else if (ev && m_ecnt < 255) m_ecnt++;
  endtask

  task automatic check_all();
    chk("phase_idx", phase_idx_o, m_idx);
    chk("phase_valid", phase_valid_o, m_valid);
    chk("phase_onehot", phase_onehot_o, m_valid ? (32'd1 << m_idx) : 32'd0);
    chk("rev_tick", rev_tick_o, m_tick);
    chk("rev_count", rev_count_o, m_rev);
    chk("seq_err", seq_err_o, m_err);
`ifdef JPD_ERR_COUNT_EN
    chk("err_count", err_count_o, m_ecnt);
`endif
  endtask

  task automatic step(input bit en, input logic [N-1:0] q, input bit clr);
    en_i = en; q_i = q; err_clr_i = clr;
    @(posedge clk_i);
    #1;
    model_step(en, q, clr);
    check_all();
  endtask

  task automatic async_reset();
    rst_n_i = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("reset_rev_count", rev_count_o, 0);
    #2;
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < P; k++) begin
      jtab[k] = v;
      v = {~v[0], v[N-1:1]};
    end
    model_reset();
    rst_n_i = 1'b0; en_i = 1'b0; err_clr_i = 1'b0; q_i = '0;
    #12;
    check_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Phase walk from reset, then wrap back to 000
    for (int k = 0; k < P; k++) begin
      step(1, jtab[k], 0);
      chk("walk_onehot", phase_onehot_o, 32'd1 << k);
    end
    step(1, jtab[0], 0);
    chk("wrap_tick", rev_tick_o, 1);
    chk("wrap_count", rev_count_o, 1);
    step(0, jtab[3], 0);
    chk("tick_one_cycle", rev_tick_o, 0);

    // 255 more revolutions wrap the 8-bit counter to 0
    for (int r = 0; r < 255; r++)
      for (int k = 1; k <= P; k++) step(1, jtab[k % P], 0);
    chk("rev_wrap_256", rev_count_o, 0);

    // Skip 100 -> 111, then 011 continues without a new error
    step(1, jtab[1], 0);
    step(1, jtab[3], 0);
    chk("skip_err", seq_err_o, 1);
    chk("skip_idx", phase_idx_o, 3);
    step(0, q_i, 1);
    step(1, jtab[4], 0);
    chk("resync_no_err", seq_err_o, 0);

    // Illegal code, then resync on 110
    step(1, 3'b101, 0);
    chk("illegal_valid", phase_valid_o, 0);
    chk("illegal_idx_hold", phase_idx_o, 4);
    step(1, jtab[2], 0);
    chk("illegal_resync_idx", phase_idx_o, 2);

    // Clear colliding with an error event: set wins
    step(1, 3'b010, 1);
    chk("clr_vs_set", seq_err_o, 1);
    step(0, 3'b010, 1);
    chk("clr_alone", seq_err_o, 0);

    // en low holds outputs while q toggles, then reset mid-phase 4
    step(1, jtab[4], 0);
    for (int i = 0; i < 6; i++) step(0, N'($urandom), 0);
    chk("hold_idx", phase_idx_o, 4);
    async_reset();
    step(1, jtab[2], 0);
    chk("post_reset_resync", seq_err_o, 0);

    // Random traffic biased toward forward stepping
    for (int i = 0; i < 3000; i++) begin
      int c;
      logic [N-1:0] qq;
      c = $urandom_range(0, 9);
      if (c < 6)      qq = jtab[(m_idx + 1) % P];
      else if (c < 8) qq = jtab[m_idx];
      else            qq = N'($urandom);
      step($urandom_range(0, 99) < 85, qq, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
